// File: rtl/zmod_spi_init_sequencer.sv
// Converter bring-up: power-up wait, then a fixed register table over 3-wire SPI.
// Raises o_init_done once the last frame and its trailing gap are complete.
module zmod_spi_init_sequencer #(
    parameter int POWERUP_TICKS = 100000,
    parameter int SCLK_DIV      = 50,
    parameter int GAP_TICKS     = 100
) (
    input  logic i_clock,
    input  logic i_nReset,
    input  logic i_restart,
    output logic o_sclk,
    output logic o_cs_n,
    output logic o_sdio,
    output logic o_busy,
    output logic o_init_done
);

    localparam int MAX_A = (POWERUP_TICKS > SCLK_DIV) ? POWERUP_TICKS : SCLK_DIV;
    localparam int MAX_T = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] PWR_LAST = TW'(POWERUP_TICKS - 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(SCLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_n;
    logic [TW-1:0] tick_q, tick_n;
    logic [5:0]    tog_q, tog_n;
    logic [1:0]    idx_q, idx_n;
    logic [23:0]   shreg_q, shreg_n;
    logic          sclk_n, cs_n_n, sdio_n, busy_n, done_n;
    logic [23:0]   frame;

    // {write, one byte, 13-bit address, data}
    always_comb begin
        frame = '0;
        case (idx_q)
            2'd0:    frame = {1'b0, 2'b00, 13'h0000, 8'h3C};
            2'd1:    frame = {1'b0, 2'b00, 13'h0014, 8'h01};
            2'd2:    frame = {1'b0, 2'b00, 13'h00FF, 8'h01};
            default: frame = '0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q     <= S_POWERUP;
            tick_q      <= '0;
            tog_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            o_sclk      <= 1'b0;
            o_cs_n      <= 1'b1;
            o_sdio      <= 1'b0;
            o_busy      <= 1'b0;
            o_init_done <= 1'b0;
        end else begin
            state_q     <= state_n;
            tick_q      <= tick_n;
            tog_q       <= tog_n;
            idx_q       <= idx_n;
            shreg_q     <= shreg_n;
            o_sclk      <= sclk_n;
            o_cs_n      <= cs_n_n;
            o_sdio      <= sdio_n;
            o_busy      <= busy_n;
            o_init_done <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        tog_n   = tog_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;
        sclk_n  = o_sclk;
        cs_n_n  = o_cs_n;
        sdio_n  = o_sdio;
        busy_n  = o_busy;
        done_n  = o_init_done;
        case (state_q)
            S_POWERUP: begin
                busy_n = 1'b0;
                done_n = 1'b0;
                tick_n = tick_q + 1'b1;
                if (tick_q == PWR_LAST) begin
                    tick_n  = '0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_n = frame;
                cs_n_n  = 1'b0;
                sdio_n  = frame[23];
                sclk_n  = 1'b0;
                busy_n  = 1'b1;
                done_n  = 1'b0;
                tick_n  = '0;
                tog_n   = '0;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                busy_n = 1'b1;
                tick_n = tick_q + 1'b1;
                if (tick_q == DIV_LAST) begin
                    tick_n = '0;
                    tog_n  = tog_q + 1'b1;
                    if (tog_q == 6'd47) begin
                        sclk_n  = 1'b0;
                        cs_n_n  = 1'b1;
                        sdio_n  = 1'b0;
                        state_n = S_GAP;
                    end else begin
                        sclk_n = ~o_sclk;
                        // next bit goes out on the falling toggle
                        if (o_sclk) begin
                            shreg_n = shreg_q << 1;
                            sdio_n  = shreg_q[22];
                        end
                    end
                end
            end
            S_GAP: begin
                busy_n = 1'b1;
                tick_n = tick_q + 1'b1;
                if (tick_q == GAP_LAST) begin
                    tick_n = '0;
                    if (idx_q < 2'd2) begin
                        idx_n   = idx_q + 2'd1;
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_n = 1'b0;
                done_n = 1'b1;
                if (i_restart) begin
                    idx_n   = '0;
                    state_n = S_LOAD;
                end
            end
            default: state_n = S_POWERUP;
        endcase
    end

endmodule

// File: tb/tb_zmod_spi_init_sequencer.sv
// Bench for zmod_spi_init_sequencer: timeline model, SPI frame monitor,
// directed restart / mid-frame reset scenarios, and a fast-clock corner instance.
module tb_zmod_spi_init_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    logic restart2 = 1'b0;
    logic sclk1, cs1, sdio1, busy1, done1;
    logic sclk2, cs2, sdio2, busy2, done2;

    int tests = 0;
    int fails = 0;
    int n;
    int org1 = 11;
    logic pre1 = 1'b0;

    logic [23:0] frames [3] = '{24'h00003C, 24'h001401, 24'h00FF01};

    always #5 clk = ~clk;

    zmod_spi_init_sequencer #(
        .POWERUP_TICKS(10), .SCLK_DIV(2), .GAP_TICKS(4)
    ) dut1 (
        .i_clock(clk), .i_nReset(rst_n), .i_restart(restart),
        .o_sclk(sclk1), .o_cs_n(cs1), .o_sdio(sdio1),
        .o_busy(busy1), .o_init_done(done1)
    );

    zmod_spi_init_sequencer #(
        .POWERUP_TICKS(3), .SCLK_DIV(1), .GAP_TICKS(1)
    ) dut2 (
        .i_clock(clk), .i_nReset(rst_n), .i_restart(restart2),
        .o_sclk(sclk2), .o_cs_n(cs2), .o_sdio(sdio2),
        .o_busy(busy2), .o_init_done(done2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, n);
        end
    endtask

    // Outputs after rising edge n, for a sequence whose first frame starts at edge org.
    // Returns {cs_n, sclk, sdio, busy, init_done}.
    function automatic logic [4:0] exp_out(input int cyc, input int org,
                                           input logic pre_done, input int d, input int g);
        int t, k, f, r, tg;
        logic [23:0] fr;
        t = 1 + 48 * d + g;
        k = cyc - org;
        if (k < 0) return {4'b1000, pre_done};
        if (k >= 3 * t) return 5'b10001;
        f = k / t;
        r = k % t;
        if (r < 48 * d) begin
            tg = r / d;
            fr = frames[f];
            return {1'b0, 1'(tg % 2), fr[23 - tg / 2], 1'b1, 1'b0};
        end
        return 5'b10010;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else n <= n + 1;
    end

    always @(negedge clk) begin
        logic [4:0] e1, e2;
        if (!rst_n) begin
            e1 = 5'b10000;
            e2 = 5'b10000;
        end else begin
            e1 = exp_out(n, org1, pre1, 2, 4);
            e2 = exp_out(n, 4, 1'b0, 1, 1);
        end
        check("cyc_dut1", {27'd0, cs1, sclk1, sdio1, busy1, done1}, {27'd0, e1});
        check("cyc_dut2", {27'd0, cs2, sclk2, sdio2, busy2, done2}, {27'd0, e2});
        if (busy1 && done1) check("busy_and_done", 1, 0);
    end

    logic [23:0] mon_sh = '0;
    int mon_bits = 0;
    int mon_idx = 0;
    int frames_seen = 0;

    always @(posedge sclk1) begin
        if (!cs1) begin
            mon_sh = {mon_sh[22:0], sdio1};
            mon_bits++;
        end
    end

    always @(posedge cs1) begin
        if (rst_n) begin
            check("frame_bits", mon_bits, 24);
            check("frame_data", {8'd0, mon_sh}, {8'd0, frames[mon_idx]});
            mon_idx = (mon_idx + 1) % 3;
            frames_seen++;
        end
        mon_bits = 0;
    end

    always @(negedge rst_n) begin
        mon_bits = 0;
        mon_idx = 0;
    end

    task automatic wait_done1(output int at);
        at = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done1) begin
                at = n;
                break;
            end
        end
    endtask

    initial begin
        int falls1[$], rises1[$], falls2[$], rises2[$];
        int d1at, d2at, at, r;
        logic prev1, prev2;

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs1, 1);
        check("rst_sclk", sclk1, 0);
        check("rst_sdio", sdio1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);

        // first run, with a restart pulse landing in S_SHIFT
        rst_n = 1'b1;
        prev1 = 1'b1;
        prev2 = 1'b1;
        d1at = -1;
        d2at = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            restart = (n == 50);
            if (prev1 && !cs1) falls1.push_back(n);
            if (!prev1 && cs1) rises1.push_back(n);
            if (prev2 && !cs2) falls2.push_back(n);
            if (!prev2 && cs2) rises2.push_back(n);
            prev1 = cs1;
            prev2 = cs2;
            if (done2 && d2at < 0) d2at = n;
            if (done1) begin
                d1at = n;
                break;
            end
        end
        restart = 1'b0;

        check("first_fall", falls1.size() > 0 ? falls1[0] : -1, 11);
        check("n_windows", falls1.size(), 3);
        check("n_rises", rises1.size(), 3);
        for (int i = 0; i < falls1.size() && i < rises1.size(); i++)
            check("win_len", rises1[i] - falls1[i], 96);
        for (int i = 0; i + 1 < falls1.size() && i < rises1.size(); i++)
            check("gap_len", falls1[i + 1] - rises1[i], 5);
        check("done_at", d1at, 314);
        check("frames_seen_1", frames_seen, 3);

        check("c_first_fall", falls2.size() > 0 ? falls2[0] : -1, 4);
        check("c_n_windows", falls2.size(), 3);
        for (int i = 0; i < falls2.size() && i < rises2.size(); i++)
            check("c_win_len", rises2[i] - falls2[i], 48);
        for (int i = 0; i + 1 < falls2.size() && i < rises2.size(); i++)
            check("c_gap_len", falls2[i + 1] - rises2[i], 2);
        check("c_done_at", d2at, 154);

        // restart from S_DONE
        repeat (5) @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        r = n;
        org1 = r + 1;
        pre1 = 1'b1;
        @(negedge clk);
        check("rs_done_hold", done1, 1);
        @(negedge clk);
        check("rs_done_drop", done1, 0);
        check("rs_busy", busy1, 1);
        check("rs_cs_fall", cs1, 0);
        wait_done1(at);
        check("rs_done_at", at, r + 1 + 303);
        check("frames_seen_2", frames_seen, 6);

        // restart again, then reset during the 10th bit of frame 1
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        org1 = n + 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (n == org1 + 101 + 37) break;
        end
        check("mid_in_frame", cs1, 0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_cs_n", cs1, 1);
        check("mid_sclk", sclk1, 0);
        check("mid_sdio", sdio1, 0);
        check("mid_busy", busy1, 0);
        check("mid_done", done1, 0);
        org1 = 11;
        pre1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_done1(at);
        check("rerun_done_at", at, 314);
        check("frames_seen_3", frames_seen, 10);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
